serial_tx_scheduler: RTL and testbench
======================================

# serial_tx_scheduler

Round-robin scheduler that shares the single hex-to-ASCII serial transmitter between `N_REQ` requesters. It latches the winning requester's 64-bit value and digit count and presents them to the transmitter with the required setup sequence. It then holds the transmitter's start level for the entire frame, waits for the transmitter's done handshake, and acknowledges the requester. It sits between the measurement/producer blocks and the transmitter, in the transmitter's 9600 Hz clock domain.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `SETUP_CYCLES`, 2: cycles the real value/number are held stable before start rises (≥1).
- `GAP_CYCLES`, 2: idle cycles, start low, between frames (≥1).
- `TIMEOUT`, 200: max cycles in SEND awaiting done (≥170).
- `IN_clk` in 1: single clock; all logic on rising edge.
- `IN_rst` in 1: asynchronous, active-high reset.
- `IN_req` in N_REQ: per-requester request level; held until matching ack.
- `IN_value` in 64*N_REQ: requester i's value at bits [64i+63:64i]; nibble 0 is sent first.
- `IN_number` in 5*N_REQ: requester i's digit count at [5i+4:5i].
- `OUT_ack` out N_REQ: one-cycle pulse to the requester whose frame ended.
- `OUT_timeout` out 1: one-cycle pulse, coincident with ack, when the frame was aborted.
- `OUT_busy` out 1: high in every state except IDLE.
- `OUT_grant_id` out max(1,ceil(log2 N_REQ)): index of the current/last grant.
- `OUT_tx_value` out 64: value to the transmitter.
- `OUT_tx_number` out 5: digit count to the transmitter.
- `OUT_tx_finish` out 1: transmitter start level; high for the whole frame.
- `IN_tx_done` in 1: transmitter handshake; high once all 160 bits are sent.

## Operation
- States: IDLE, LOAD, SETUP, SEND, RELEASE, GAP.
- IDLE: if any `IN_req` bit is set, pick by round-robin starting at `rr_ptr`. Latch that requester's value and clamped number, set `OUT_grant_id`, and go to LOAD. Otherwise stay.
- Clamp: number > 16 is latched as 16. 0 is legal; the transmitter then sends an all-idle (all ones) frame.
- LOAD, 1 cycle: `OUT_tx_number`=0 and `OUT_tx_value`=latched value. This forces the transmitter to rebuild its frame even when consecutive jobs share a digit count. Next state is SETUP.
- SETUP, `SETUP_CYCLES` cycles: `OUT_tx_number`=latched number with finish low. Next state is SEND.
- SEND: finish high. Leave when `IN_tx_done` is sampled high. Leave with timeout flagged if the cycle counter reaches `TIMEOUT`.
- RELEASE, 1 cycle: finish low and `OUT_ack[grant]`=1. `OUT_timeout`=1 if the frame aborted. `rr_ptr` ← grant+1, wrapping modulo `N_REQ`. Next state is GAP.
- GAP, `GAP_CYCLES` cycles: finish low. Next state is IDLE.
- Requests are sampled only in IDLE. A deassertion mid-job does not abort; the frame completes and ack still pulses. A new request arriving during a job waits.
- `OUT_tx_value`/`OUT_tx_number` stay constant from SETUP to the end of SEND. They keep their last value in RELEASE, GAP and IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, `rr_ptr`=0, counters 0.
- Reset mid-frame: finish drops asynchronously and no ack is issued. The job is lost; the requester re-requests.
- Request sampled at edge k: LOAD in cycle k+1, SETUP in k+2..k+1+SETUP_CYCLES, finish rises at edge k+2+SETUP_CYCLES.
- Done sampled at edge d: finish falls and ack pulses at edge d+1. The next IDLE sample is at edge d+2+GAP_CYCLES.
- Minimum finish-low time between frames: 1+GAP_CYCLES+1+SETUP_CYCLES+1 cycles.
- Timeout: the counter starts at 0 on SEND entry and aborts in the cycle it equals `TIMEOUT`-1.
- Done and timeout in the same cycle: done wins and `OUT_timeout` stays 0.
- `IN_tx_done` is ignored outside SEND.

## Structure
- Shared package `serial_pkg`:
  - state enum;
  - `SER_MAX_DIGITS`=16;
  - `SER_CHAR_BITS`=10;
  - `SER_FRAME_BITS`=160;
  - clamp function for the digit count.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs are `req[N_REQ]` and `ptr`; outputs are `gnt_id` and `any`. It is reused by other shared-resource blocks.
- The top level holds the FSM, latches and counters.

## Test plan
- Single request: req[2] with value 64'h0123_4567_89AB_CDEF and number 5. Expect LOAD tx_number=0, then 5. Finish rises 4 cycles after the sample. Done after 160 cycles gives ack[2] one cycle later, and grant_id=2.
- Contention: req=4'b1111 held, with done returned each frame. Expect grants in order 0,1,2,3,0. At least 1+GAP+1+SETUP+1 cycles of finish-low between frames.
- Same-number back-to-back: two jobs with number 8. Expect tx_number sequence 8→0→8 between frames.
- Clamp/zero: number 31 gives tx_number=16. Number 0 still completes with ack.
- Timeout: done held low. Expect finish low and ack+timeout pulsing together at SEND cycle 200, then the next requester is served.
- Reset during SEND: finish 0 immediately, no ack. After release, the pending req is served from `rr_ptr`=0.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared types, frame constants and digit-count clamp for the serial transmitter path
package serial_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SEND, S_RELEASE, S_GAP} state_t;
    localparam int SER_MAX_DIGITS = 16;
    localparam int SER_CHAR_BITS  = 10;
    localparam int SER_FRAME_BITS = SER_MAX_DIGITS * SER_CHAR_BITS;
    function automatic logic [4:0] clamp_digits(input logic [4:0] n);
        return (n > 5'(SER_MAX_DIGITS)) ? 5'(SER_MAX_DIGITS) : n;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   gnt_id,
    output logic             any
);
    logic [IDW-1:0] idx;
    // scan offsets from farthest to nearest so the requester closest to ptr wins
    always_comb begin
        gnt_id = ptr;
        idx    = ptr;
        any    = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = IDW'((int'(ptr) + i) % N_REQ);
            if (req[idx]) gnt_id = idx;
        end
    end
endmodule

// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: round-robin sharing of one hex-to-ASCII serial transmitter among requesters
module serial_tx_scheduler
    import serial_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 200
) (
    input  logic                       IN_clk,
    input  logic                       IN_rst,
    input  logic [N_REQ-1:0]           IN_req,
    input  logic [64*N_REQ-1:0]        IN_value,
    input  logic [5*N_REQ-1:0]         IN_number,
    output logic [N_REQ-1:0]           OUT_ack,
    output logic                       OUT_timeout,
    output logic                       OUT_busy,
    output logic [$clog2(N_REQ)-1:0]   OUT_grant_id,
    output logic [63:0]                OUT_tx_value,
    output logic [4:0]                 OUT_tx_number,
    output logic                       OUT_tx_finish,
    input  logic                       IN_tx_done
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = 16;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   rr_q, rr_d, grant_q, grant_d, pick;
    logic [63:0]      val_q, val_d, tx_value_q, tx_value_d;
    logic [4:0]       num_q, num_d, tx_number_q, tx_number_d;
    logic             aborted_q, aborted_d, finish_q, finish_d, timeout_q, timeout_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             any_req;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req(IN_req), .ptr(rr_q), .gnt_id(pick), .any(any_req)
    );

    // next state, job latches and the transmitter-facing outputs, which trail the state by one cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        val_d       = val_q;
        num_d       = num_q;
        aborted_d   = aborted_q;
        tx_value_d  = (state_q == S_LOAD) ? val_q : tx_value_q;
        tx_number_d = (state_q == S_LOAD) ? 5'd0 : (state_q == S_SETUP) ? num_q : tx_number_q;
        finish_d    = state_q == S_SEND;
        timeout_d   = (state_q == S_RELEASE) && aborted_q;
        ack_d       = '0;
        if (state_q == S_RELEASE) ack_d[grant_q] = 1'b1;
        case (state_q)
            S_IDLE: if (any_req) begin
                grant_d = pick;
                val_d   = IN_value[64*int'(pick) +: 64];
                num_d   = clamp_digits(IN_number[5*int'(pick) +: 5]);
                state_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                cnt_d     = (cnt_q == CW'(SETUP_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
                aborted_d = 1'b0;
                state_d   = (cnt_q == CW'(SETUP_CYCLES - 1)) ? S_SEND : S_SETUP;
            end
            S_SEND: begin
                cnt_d     = cnt_q + 1'b1;
                aborted_d = !IN_tx_done && (cnt_q == CW'(TIMEOUT - 1));
                state_d   = (IN_tx_done || cnt_q == CW'(TIMEOUT - 1)) ? S_RELEASE : S_SEND;
            end
            S_RELEASE: begin
                rr_d    = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                cnt_d   = (cnt_q == CW'(GAP_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(GAP_CYCLES - 1)) ? S_IDLE : S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and output registers; reset drops finish immediately and discards any job in flight
    always_ff @(posedge IN_clk or posedge IN_rst) begin
        if (IN_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rr_q        <= '0;
            grant_q     <= '0;
            val_q       <= '0;
            num_q       <= '0;
            aborted_q   <= 1'b0;
            tx_value_q  <= '0;
            tx_number_q <= '0;
            finish_q    <= 1'b0;
            timeout_q   <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            val_q       <= val_d;
            num_q       <= num_d;
            aborted_q   <= aborted_d;
            tx_value_q  <= tx_value_d;
            tx_number_q <= tx_number_d;
            finish_q    <= finish_d;
            timeout_q   <= timeout_d;
            ack_q       <= ack_d;
        end
    end

    assign OUT_ack       = ack_q;
    assign OUT_timeout   = timeout_q;
    assign OUT_busy      = state_q != S_IDLE;
    assign OUT_grant_id  = grant_q;
    assign OUT_tx_value  = tx_value_q;
    assign OUT_tx_number = tx_number_q;
    assign OUT_tx_finish = finish_q;
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: randomized scoreboard bench for the transmitter scheduler
module tb_serial_tx_scheduler;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int G  = 2;
    localparam int TO = 200;
    localparam int NEVER = 1000;

    typedef struct {
        int          id;
        logic [63:0] value;
        logic [4:0]  number;
        logic        to;
        int          lat;
    } exp_t;

    logic            IN_clk = 1'b0;
    logic            IN_rst = 1'b1;
    logic [N-1:0]    IN_req = '0;
    logic [64*N-1:0] IN_value = '0;
    logic [5*N-1:0]  IN_number = '0;
    logic [N-1:0]    OUT_ack;
    logic            OUT_timeout, OUT_busy, OUT_tx_finish;
    logic [1:0]      OUT_grant_id;
    logic [63:0]     OUT_tx_value;
    logic [4:0]      OUT_tx_number;
    logic            IN_tx_done = 1'b0;

    serial_tx_scheduler #(.N_REQ(N), .SETUP_CYCLES(S), .GAP_CYCLES(G), .TIMEOUT(TO)) dut (
        .IN_clk(IN_clk), .IN_rst(IN_rst), .IN_req(IN_req), .IN_value(IN_value),
        .IN_number(IN_number), .OUT_ack(OUT_ack), .OUT_timeout(OUT_timeout),
        .OUT_busy(OUT_busy), .OUT_grant_id(OUT_grant_id), .OUT_tx_value(OUT_tx_value),
        .OUT_tx_number(OUT_tx_number), .OUT_tx_finish(OUT_tx_finish), .IN_tx_done(IN_tx_done)
    );

    always #5 IN_clk = ~IN_clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];
    int   dq[$];
    int   rr_m = 0;
    logic [63:0] vals[N];
    logic [4:0]  nums[N];
    int          dlys[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // transmitter model: pulses done a chosen number of cycles after finish rises
    initial begin
        bit tx_active = 0;
        int j = 0;
        int dly = NEVER;
        forever begin
            @(posedge IN_clk); #1;
            IN_tx_done = 1'b0;
            if (!OUT_tx_finish) tx_active = 0;
            else begin
                if (!tx_active) begin
                    tx_active = 1;
                    j = 0;
                    dly = (dq.size() != 0) ? dq.pop_front() : NEVER;
                end else j++;
                if (j == dly) IN_tx_done = 1'b1;
            end
        end
    end

    // monitor: checks each frame start and each ack against the scoreboard front
    initial begin
        int cyc = 0, rise_c = 0, fall_c = 0, busy_rise = 0;
        bit fin_p = 0, busy_p = 0, skip_gap = 1;
        logic [4:0] h1 = '0, h2 = '0, h3 = '0;
        exp_t e;
        forever begin
            @(posedge IN_clk); #1;
            cyc++;
            if (IN_rst) skip_gap = 1;
            if (OUT_tx_finish && !fin_p) begin
                rise_c = cyc;
                if (exp_q.size() == 0) chk("unexpected_frame", 64'd1, 64'd0);
                else begin
                    e = exp_q[0];
                    chk("grant_id", 64'(OUT_grant_id), 64'(e.id));
                    chk("tx_value", OUT_tx_value, e.value);
                    chk("tx_number", 64'(OUT_tx_number), 64'(e.number));
                    chk("setup_number_1", 64'(h1), 64'(e.number));
                    chk("setup_number_2", 64'(h2), 64'(e.number));
                    chk("load_number_zero", 64'(h3), 64'd0);
                    chk("finish_rise_delay", 64'(cyc - busy_rise), 64'(2 + S));
                    if (!skip_gap) chk("min_finish_low", 64'(cyc - fall_c >= 3 + G + S), 64'd1);
                    skip_gap = 0;
                end
            end
            if (!OUT_tx_finish && fin_p) fall_c = cyc;
            if (OUT_ack != '0) begin
                if (exp_q.size() == 0) chk("unexpected_ack", 64'(OUT_ack), 64'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("ack_onehot", 64'(OUT_ack), 64'(1) << e.id);
                    chk("ack_timeout", 64'(OUT_timeout), 64'(e.to));
                    chk("finish_low_at_ack", 64'(OUT_tx_finish), 64'd0);
                    chk("ack_latency", 64'(cyc - rise_c), 64'(e.lat));
                    chk("value_held", OUT_tx_value, e.value);
                    chk("number_held", 64'(OUT_tx_number), 64'(e.number));
                end
            end else if (OUT_timeout) chk("timeout_without_ack", 64'd1, 64'd0);
            if (OUT_busy && !busy_p) busy_rise = cyc;
            fin_p = OUT_tx_finish;
            busy_p = OUT_busy;
            h3 = h2; h2 = h1; h1 = OUT_tx_number;
        end
    end

    task automatic set_job(input int i, input logic [63:0] v, input logic [4:0] n, input int d);
        vals[i] = v; nums[i] = n; dlys[i] = d;
    endtask

    // reference model: all masked requesters are served once, in cyclic order from the model pointer
    task automatic queue_batch(input logic [N-1:0] mask);
        exp_t e;
        int last = rr_m;
        for (int k = 0; k < N; k++) begin
            int i = (rr_m + k) % N;
            if (mask[i]) begin
                e.id = i;
                e.value = vals[i];
                e.number = (nums[i] > 5'd16) ? 5'd16 : nums[i];
                e.to = dlys[i] >= TO - 1;
                e.lat = (dlys[i] >= TO - 1) ? TO : dlys[i] + 2;
                exp_q.push_back(e);
                dq.push_back(dlys[i]);
                last = i;
            end
        end
        rr_m = (last + 1) % N;
        for (int i = 0; i < N; i++) begin
            IN_value[64*i +: 64] = vals[i];
            IN_number[5*i +: 5] = nums[i];
        end
        IN_req = mask;
    endtask

    task automatic wait_batch();
        for (int c = 0; c < 4000 && exp_q.size() != 0; c++) begin
            @(posedge IN_clk); #2;
            IN_req &= ~OUT_ack;
            if (OUT_tx_finish && exp_q.size() != 0 && $urandom_range(0, 7) == 0) IN_req[exp_q[0].id] = 1'b0;
        end
        if (exp_q.size() != 0) begin
            chk("batch_drained", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            dq.delete();
        end
        IN_req = '0;
    endtask

    task automatic run_batch(input logic [N-1:0] mask);
        queue_batch(mask);
        wait_batch();
    endtask

    initial begin
        logic [N-1:0] m;
        repeat (3) @(posedge IN_clk);
        #2;
        chk("rst_ack", 64'(OUT_ack), 64'd0);
        chk("rst_timeout", 64'(OUT_timeout), 64'd0);
        chk("rst_busy", 64'(OUT_busy), 64'd0);
        chk("rst_grant", 64'(OUT_grant_id), 64'd0);
        chk("rst_tx_value", OUT_tx_value, 64'd0);
        chk("rst_tx_number", 64'(OUT_tx_number), 64'd0);
        chk("rst_finish", 64'(OUT_tx_finish), 64'd0);
        IN_rst = 1'b0;
        repeat (2) @(posedge IN_clk);
        #2;
        set_job(2, 64'h0123_4567_89AB_CDEF, 5'd5, 158);
        run_batch(4'b0100);
        for (int i = 0; i < N; i++) set_job(i, {$urandom, $urandom}, 5'($urandom_range(1, 16)), $urandom_range(0, 12));
        run_batch(4'b1111);
        run_batch(4'b1111);
        set_job(0, 64'hAAAA_5555_AAAA_5555, 5'd8, 3);
        set_job(1, 64'h1111_2222_3333_4444, 5'd8, 4);
        run_batch(4'b0011);
        set_job(1, 64'hFEDC_BA98_7654_3210, 5'd31, 2);
        set_job(3, 64'h0, 5'd0, 1);
        run_batch(4'b1010);
        set_job(0, 64'hDEAD_BEEF_0000_0001, 5'd12, NEVER);
        set_job(1, 64'hC0FF_EE00_1234_5678, 5'd7, 5);
        run_batch(4'b0011);
        set_job(0, 64'h0F0F_0F0F_0F0F_0F0F, 5'd16, TO - 2);
        set_job(2, 64'hF0F0_F0F0_F0F0_F0F0, 5'd17, TO - 1);
        run_batch(4'b0101);
        for (int b = 0; b < 15; b++) begin
            for (int i = 0; i < N; i++) begin
                int r = $urandom_range(0, 11);
                set_job(i, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                        (r == 0) ? NEVER : (r == 1) ? TO - 2 : (r == 2) ? TO - 1 : $urandom_range(0, 30));
            end
            m = 4'($urandom_range(1, 15));
            run_batch(m);
        end
        set_job(3, 64'h3333_3333_3333_3333, 5'd9, NEVER);
        queue_batch(4'b1000);
        for (int c = 0; c < 50 && !OUT_tx_finish; c++) begin
            @(posedge IN_clk); #2;
        end
        chk("finish_before_reset", 64'(OUT_tx_finish), 64'd1);
        repeat (3) @(posedge IN_clk);
        #3;
        IN_rst = 1'b1;
        #1;
        chk("rst_mid_finish", 64'(OUT_tx_finish), 64'd0);
        chk("rst_mid_ack", 64'(OUT_ack), 64'd0);
        chk("rst_mid_busy", 64'(OUT_busy), 64'd0);
        exp_q.delete();
        dq.delete();
        rr_m = 0;
        set_job(1, 64'h1010_2020_3030_4040, 5'd4, 6);
        set_job(3, 64'h3333_3333_3333_3333, 5'd9, 2);
        queue_batch(4'b1010);
        repeat (2) @(posedge IN_clk);
        #2;
        IN_rst = 1'b0;
        wait_batch();
        repeat (10) @(posedge IN_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
